// File: rtl/ibex_rf_ctx_sequencer_if.sv
// ibex_rf_ctx_sequencer_if: save/restore context streams between the sequencer and its peer
interface ibex_rf_ctx_sequencer_if #(parameter int DataWidth = 32);
  logic                 ctx_valid_o;
  logic [DataWidth-1:0] ctx_data_o;
  logic                 ctx_ready_i;
  logic                 ctx_valid_i;
  logic [DataWidth-1:0] ctx_data_i;
  logic                 ctx_ready_o;
  modport master (output ctx_valid_o, ctx_data_o, ctx_ready_o, input ctx_ready_i, ctx_valid_i, ctx_data_i);
  modport slave (input ctx_valid_o, ctx_data_o, ctx_ready_o, output ctx_ready_i, ctx_valid_i, ctx_data_i);
endinterface

// File: rtl/ibex_rf_ctx_sequencer.sv
// ibex_rf_ctx_sequencer: streams the integer RF out (save) or back in (restore) while the core is halted
module ibex_rf_ctx_sequencer #(
  parameter bit RV32E     = 1'b0,
  parameter int DataWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 core_halted_i,
  input  logic                 save_req_i,
  input  logic                 restore_req_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic                 rf_sel_o,
  output logic [4:0]           rf_raddr_o,
  input  logic [DataWidth-1:0] rf_rdata_i,
  output logic [4:0]           rf_waddr_o,
  output logic [DataWidth-1:0] rf_wdata_o,
  output logic                 rf_we_o,
  ibex_rf_ctx_sequencer_if.master ctx
);
  localparam logic [4:0] Last = RV32E ? 5'd15 : 5'd31;
  typedef enum logic [1:0] {IDLE, SAVE_RD, SAVE_OUT, RESTORE} state_e;
  state_e               state_q, state_d;
  logic [4:0]           idx_q, idx_d;
  logic [DataWidth-1:0] data_q, data_d;
  logic                 done_q, done_d, err_q, err_d;
  logic                 last;
  assign last = idx_q == Last;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      idx_q   <= 5'd1;
      data_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end
  always_comb begin
    state_d         = state_q;
    idx_d           = idx_q;
    data_d          = data_q;
    done_d          = 1'b0;
    err_d           = 1'b0;
    rf_raddr_o      = 5'd0;
    rf_waddr_o      = 5'd0;
    rf_wdata_o      = '0;
    rf_we_o         = 1'b0;
    ctx.ctx_valid_o = 1'b0;
    ctx.ctx_data_o  = '0;
    ctx.ctx_ready_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (core_halted_i && (save_req_i || restore_req_i)) begin
          state_d = save_req_i ? SAVE_RD : RESTORE;
          idx_d   = 5'd1;
        end
      end
      SAVE_RD: begin
        rf_raddr_o = idx_q;
        data_d     = rf_rdata_i;
        state_d    = SAVE_OUT;
      end
      SAVE_OUT: begin
        rf_raddr_o      = idx_q;
        ctx.ctx_valid_o = 1'b1;
        ctx.ctx_data_o  = data_q;
        if (ctx.ctx_ready_i) begin
          state_d = last ? IDLE : SAVE_RD;
          idx_d   = last ? idx_q : idx_q + 5'd1;
          done_d  = last;
        end
      end
      RESTORE: begin
        ctx.ctx_ready_o = 1'b1;
        rf_waddr_o      = idx_q;
        rf_wdata_o      = ctx.ctx_data_i;
        rf_we_o         = ctx.ctx_valid_i;
        if (ctx.ctx_valid_i) begin
          state_d = last ? IDLE : RESTORE;
          idx_d   = last ? idx_q : idx_q + 5'd1;
          done_d  = last;
        end
      end
      default: state_d = IDLE;
    endcase
    // losing the halt kills the handshake in the same cycle so nothing is transferred or written
    if (state_q != IDLE && !core_halted_i) begin
      state_d         = IDLE;
      idx_d           = 5'd1;
      done_d          = 1'b0;
      err_d           = 1'b1;
      rf_we_o         = 1'b0;
      ctx.ctx_valid_o = 1'b0;
      ctx.ctx_ready_o = 1'b0;
    end
  end
  assign busy_o   = state_q != IDLE;
  assign rf_sel_o = state_q != IDLE;
  assign done_o   = done_q;
  assign err_o    = err_q;
endmodule

// File: tb/tb_ibex_rf_ctx_sequencer.sv
// tb_ibex_rf_ctx_sequencer: scoreboard bench for save, restore, abort and RV32E sequencing
module tb_ibex_rf_ctx_sequencer;
  logic clk, rst_n;
  logic halted, save_req, restore_req, busy, done, err, sel, we;
  logic [4:0] raddr, waddr;
  logic [31:0] rdata, wdata;
  logic e_halted, e_save, e_busy, e_done, e_err, e_sel, e_we;
  logic [4:0] e_raddr, e_waddr;
  logic [31:0] e_rdata, e_wdata;
  logic [31:0] rf [32];
  logic [31:0] rf_e [32];
  logic [31:0] sb [$];
  logic [31:0] sb_e [$];
  logic [36:0] wq [$];
  int n_chk = 0, n_fail = 0;
  int n_busy, n_done, n_err, n_wr, n_eb, n_edone;
  logic stall_q;
  logic [31:0] stall_data;
  ibex_rf_ctx_sequencer_if #(.DataWidth(32)) cif ();
  ibex_rf_ctx_sequencer_if #(.DataWidth(32)) eif ();
  ibex_rf_ctx_sequencer #(.RV32E(1'b0), .DataWidth(32)) dut (
    .clk_i(clk), .rst_ni(rst_n), .core_halted_i(halted), .save_req_i(save_req),
    .restore_req_i(restore_req), .busy_o(busy), .done_o(done), .err_o(err), .rf_sel_o(sel),
    .rf_raddr_o(raddr), .rf_rdata_i(rdata), .rf_waddr_o(waddr), .rf_wdata_o(wdata),
    .rf_we_o(we), .ctx(cif)
  );
  ibex_rf_ctx_sequencer #(.RV32E(1'b1), .DataWidth(32)) dut_e (
    .clk_i(clk), .rst_ni(rst_n), .core_halted_i(e_halted), .save_req_i(e_save),
    .restore_req_i(1'b0), .busy_o(e_busy), .done_o(e_done), .err_o(e_err), .rf_sel_o(e_sel),
    .rf_raddr_o(e_raddr), .rf_rdata_i(e_rdata), .rf_waddr_o(e_waddr), .rf_wdata_o(e_wdata),
    .rf_we_o(e_we), .ctx(eif)
  );
  assign rdata   = rf[raddr];
  assign e_rdata = rf_e[e_raddr];
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask
  task automatic clear();
    n_busy = 0; n_done = 0; n_err = 0; n_wr = 0;
  endtask
  // negedge monitor: RF model writes, stream scoreboards, event counters
  initial begin
    logic [36:0] e;
    for (int i = 0; i < 32; i++) begin
      rf[i]   = 32'h1000 + i;
      rf_e[i] = 32'h2000 + i;
    end
    rf[0] = 0; rf_e[0] = 0;
    stall_q = 0; stall_data = 0; n_eb = 0; n_edone = 0;
    clear();
    forever begin
      @(negedge clk);
      if (!rst_n) stall_q = 0;
      else begin
        if (busy) n_busy++;
        if (done) n_done++;
        if (err) n_err++;
        if (stall_q && cif.ctx_valid_o) check("stall_hold", cif.ctx_data_o, stall_data);
        stall_q = cif.ctx_valid_o && !cif.ctx_ready_i;
        stall_data = cif.ctx_data_o;
        if (cif.ctx_valid_o && cif.ctx_ready_i) begin
          if (sb.size() == 0) check("save_extra", 1, 0);
          else check("save_beat", cif.ctx_data_o, sb.pop_front());
        end
        if (we) begin
          n_wr++;
          rf[waddr] = wdata;
          if (wq.size() == 0) check("we_extra", 1, 0);
          else begin
            e = wq.pop_front();
            check("wr_addr", waddr, e[36:32]);
            check("wr_data", wdata, e[31:0]);
          end
        end
        if (e_done) n_edone++;
        if (eif.ctx_valid_o && eif.ctx_ready_i) begin
          n_eb++;
          if (sb_e.size() == 0) check("e_extra", 1, 0);
          else check("e_beat", eif.ctx_data_o, sb_e.pop_front());
        end
      end
    end
  end
  task automatic do_save(input logic [31:0] base, input bit toggle);
    clear();
    for (int k = 1; k < 32; k++) sb.push_back(base + k);
    halted = 1; save_req = 1; cif.ctx_ready_i = !toggle;
    for (int c = 0; c < 400 && n_done == 0 && n_err == 0; c++) begin
      @(posedge clk); #1;
      save_req = 0; restore_req = 0;
      if (toggle) cif.ctx_ready_i = (c % 3 == 2);
    end
    cif.ctx_ready_i = 0;
    repeat (3) @(posedge clk);
    #1;
    check("save_done", n_done, 1);
    check("save_err", n_err, 0);
    check("save_left", sb.size(), 0);
    if (!toggle) check("save_busy", n_busy, 62);
    sb.delete();
  endtask
  task automatic do_restore(input int abort_at);
    int n;
    clear();
    n = abort_at != 0 ? abort_at : 31;
    for (int k = 1; k <= n; k++) wq.push_back({k[4:0], 32'hA000 + k});
    halted = 1; restore_req = 1; cif.ctx_valid_i = 1; cif.ctx_data_i = 32'hA001;
    for (int c = 0; c < 200 && n_done == 0 && n_err == 0; c++) begin
      @(posedge clk); #1;
      restore_req = 0;
      cif.ctx_data_i = 32'hA000 + n_wr + 1;
      if (abort_at != 0 && n_wr == abort_at && halted) begin
        halted = 0;
        @(negedge clk);
        check("abort_we", we, 0);
        check("abort_rdy", cif.ctx_ready_o, 0);
        @(negedge clk);
        check("abort_busy", busy, 0);
      end
    end
    cif.ctx_valid_i = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rest_writes", n_wr, n);
    check("rest_done", n_done, abort_at != 0 ? 0 : 1);
    check("rest_err", n_err, abort_at != 0 ? 1 : 0);
    check("rest_left", wq.size(), 0);
    if (abort_at == 0) check("rest_busy", n_busy, 31);
    wq.delete();
    halted = 1;
  endtask
  initial begin
    rst_n = 0; halted = 0; save_req = 0; restore_req = 0;
    cif.ctx_ready_i = 0; cif.ctx_valid_i = 0; cif.ctx_data_i = 0;
    e_halted = 0; e_save = 0; eif.ctx_ready_i = 0; eif.ctx_valid_i = 0; eif.ctx_data_i = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ctrl", {busy, done, err, sel, we, cif.ctx_valid_o, cif.ctx_ready_o}, 0);
    check("rst_addr", {raddr, waddr}, 0);
    check("rst_data", {cif.ctx_data_o, wdata}, 0);
    rst_n = 1;
    @(posedge clk); #1;
    do_save(32'h1000, 0);
    do_save(32'h1000, 1);
    do_restore(5);
    do_restore(0);
    do_save(32'hA000, 0);
    clear();
    halted = 0; save_req = 1; restore_req = 1;
    repeat (10) @(posedge clk);
    #1;
    check("nohalt_busy", n_busy, 0);
    do_save(32'hA000, 0);
    for (int k = 1; k < 32; k++) sb.push_back(32'hA000 + k);
    halted = 1; save_req = 1; cif.ctx_ready_i = 1;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 0;
    #1;
    check("midrst_busy", {busy, sel, cif.ctx_valid_o}, 0);
    save_req = 0; cif.ctx_ready_i = 0;
    @(posedge clk); #1;
    rst_n = 1; sb.delete();
    for (int k = 1; k < 16; k++) sb_e.push_back(32'h2000 + k);
    e_halted = 1; e_save = 1; eif.ctx_ready_i = 1;
    for (int c = 0; c < 100 && n_edone == 0; c++) begin
      @(posedge clk); #1;
      e_save = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    check("e_beats", n_eb, 15);
    check("e_done", n_edone, 1);
    check("e_left", sb_e.size(), 0);
    check("e_idle", {e_busy, e_sel, e_err, e_we, e_waddr, e_wdata}, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
